// File: rtl/keypad_matrix_scan.sv
// 4x4 matrix keypad scanner: one-hot active-low row drive, whole-frame debounce, press events.
// Latency: a key is accepted DB_FRAMES..DB_FRAMES+1 frames after contact settles; press pulse one cycle later.
// Backpressure: none; key_press/key_valid are single-cycle pulses and are never held off.
module keypad_matrix_scan #(
  parameter int SCAN_TICK = 50_000,
  parameter int DB_FRAMES = 5
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic [3:0]  COL,
  output logic [3:0]  ROW,
  output logic [15:0] key_state,
  output logic [15:0] key_press,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam logic [15:0] TICK_LAST = 16'(SCAN_TICK - 1);
  localparam logic [3:0]  STAB_LAST = 4'(DB_FRAMES - 1);

  logic [3:0]  col_meta;
  logic [3:0]  col_sync;
  logic [15:0] tick_cnt;
  logic [1:0]  row_idx;
  logic [1:0]  row_nxt;
  logic [15:0] raw;
  logic [15:0] frame_nxt;
  logic [15:0] last_frame;
  logic [3:0]  stab_cnt;
  logic [15:0] key_state_d;
  logic [15:0] rise;
  logic [3:0]  low_idx;
  logic        slot_end;
  logic        frame_end;

  assign slot_end  = (tick_cnt == TICK_LAST);
  assign frame_end = slot_end && (row_idx == 2'd3);
  assign row_nxt   = row_idx + 2'd1;
  assign rise      = key_state & ~key_state_d;

  // Two-flop synchronizer for the asynchronous column pins; idle lines read as pulled-up.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= COL;
      col_sync <= col_meta;
    end
  end

  // Raw frame with the currently driven row's columns merged in, used at slot end.
  always_comb begin
    frame_nxt = raw;
    for (int c = 0; c < 4; c++) begin
      frame_nxt[{row_idx, 2'(c)}] = ~col_sync[c];
    end
  end

  // Row slot timer: sample the driven row at the end of its slot, then advance the drive.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= 16'd0;
      row_idx  <= 2'd0;
      ROW      <= 4'b1110;
      raw      <= 16'd0;
    end else if (slot_end) begin
      tick_cnt <= 16'd0;
      raw      <= frame_nxt;
      row_idx  <= row_nxt;
      ROW      <= ~(4'b0001 << row_nxt);
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // Frame debounce: accept a frame only after it repeats unchanged for DB_FRAMES frame ends.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      last_frame <= 16'd0;
      stab_cnt   <= 4'd0;
      key_state  <= 16'd0;
    end else if (frame_end) begin
      if (frame_nxt != last_frame) begin
        last_frame <= frame_nxt;
        stab_cnt   <= 4'd0;
      end else if (stab_cnt == STAB_LAST) begin
        key_state  <= frame_nxt;
      end else begin
        stab_cnt   <= stab_cnt + 4'd1;
      end
    end
  end

  // Lowest newly pressed key index; scanning downward lets the lowest index win.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rise[i]) low_idx = 4'(i);
    end
  end

  // Rising-edge detect on the debounced level; key_code holds until the next press event.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      key_state_d <= 16'd0;
      key_press   <= 16'd0;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
    end else begin
      key_state_d <= key_state;
      key_press   <= rise;
      key_valid   <= |rise;
      if (|rise) key_code <= low_idx;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Randomized scoreboard bench for keypad_matrix_scan (SCAN_TICK=10, DB_FRAMES=3).
// Stimulus holds each key pattern long enough to be accepted and predicts press events from set differences.
// A monitor pops predicted events whenever the DUT pulses key_valid/key_press.
module tb_keypad_matrix_scan;

  localparam int SCAN_TICK = 10;
  localparam int DB_FRAMES = 3;
  localparam int HOLD      = 240;

  logic        CLK_50M = 1'b0;
  logic        RST_N;
  logic [3:0]  COL;
  logic [3:0]  ROW;
  logic [15:0] key_state;
  logic [15:0] key_press;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] keys;
  logic [15:0] accepted;
  logic [3:0]  last_code;
  logic [15:0] exp_vec_q[$];
  logic [3:0]  exp_code_q[$];
  logic [15:0] ev;
  logic [3:0]  ec;
  int          total = 0;
  int          bad   = 0;

  keypad_matrix_scan #(.SCAN_TICK(SCAN_TICK), .DB_FRAMES(DB_FRAMES)) dut (
    .CLK_50M   (CLK_50M),
    .RST_N     (RST_N),
    .COL       (COL),
    .ROW       (ROW),
    .key_state (key_state),
    .key_press (key_press),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always #5 CLK_50M = ~CLK_50M;

  // Keypad: a closed key pulls its column low only while its row is driven low.
  always_comb begin
    COL = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (ROW[r] == 1'b0 && keys[r*4+c]) COL[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Monitor: every pulse must match the oldest predicted press event.
  always @(negedge CLK_50M) begin
    if (RST_N === 1'b1 && (key_valid !== 1'b0 || key_press !== 16'd0)) begin
      if (exp_vec_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: key_valid=%b key_press=%h, none expected at %0t",
                 key_valid, key_press, $time);
      end else begin
        ev = exp_vec_q.pop_front();
        ec = exp_code_q.pop_front();
        chk("pulse_valid", 32'(key_valid), 32'd1);
        chk("pulse_press", 32'(key_press), 32'(ev));
        chk("pulse_code",  32'(key_code),  32'(ec));
        last_code = ec;
      end
    end
  end

  // Apply a new key pattern, optionally preceded by a short glitch or a bounce, and hold it.
  task automatic step(input logic [15:0] v, input int pre_len, input logic [15:0] gv, input bit bounce);
    logic [15:0] newp;
    newp = v & ~accepted;
    if (newp != 16'd0) begin
      exp_vec_q.push_back(newp);
      exp_code_q.push_back(lowest(newp));
    end
    if (bounce) begin
      for (int i = 0; i < pre_len; i++) begin
        if (i % 7 == 0) keys = ((i / 7) % 2 == 1) ? accepted : v;
        @(negedge CLK_50M);
      end
    end else if (pre_len > 0) begin
      keys = gv;
      repeat (pre_len) @(negedge CLK_50M);
    end
    keys = v;
    repeat (HOLD) @(negedge CLK_50M);
    accepted = v;
    chk("key_state", 32'(key_state), 32'(v));
    chk("press_arrived", 32'(exp_vec_q.size()), 32'd0);
    exp_vec_q.delete();
    exp_code_q.delete();
    chk("key_code_held", 32'(key_code), 32'(last_code));
  endtask

  initial begin
    logic [3:0]  er;
    logic [15:0] v;
    int          n;
    RST_N     = 1'b0;
    keys      = 16'd0;
    accepted  = 16'd0;
    last_code = 4'd0;
    repeat (3) @(negedge CLK_50M);
    chk("rst_row",   32'(ROW),       32'hE);
    chk("rst_state", 32'(key_state), 32'd0);
    chk("rst_press", 32'(key_press), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code",  32'(key_code),  32'd0);
    RST_N = 1'b1;

    // Idle scan for 20 frames: row drive rotates every SCAN_TICK clocks.
    for (int k = 1; k <= 20 * 4 * SCAN_TICK; k++) begin
      @(negedge CLK_50M);
      er = ~(4'b0001 << ((k / SCAN_TICK) % 4));
      chk("row_seq", 32'(ROW), 32'(er));
    end
    chk("idle_state", 32'(key_state), 32'd0);

    // Single key r2c1, then release (no pulse on release).
    step(16'h0200, 0, 16'd0, 1'b0);
    step(16'h0000, 0, 16'd0, 1'b0);
    // Bouncing idx 5 for two frames before settling closed.
    step(16'h0020, 80, 16'd0, 1'b1);
    // idx 3 and idx 12 together (idx 5 released at the same time).
    step(16'h1008, 0, 16'd0, 1'b0);
    // idx 9 held, opened for one frame, closed again: no second press.
    step(16'h0200, 0, 16'd0, 1'b0);
    step(16'h0200, 40, 16'h0000, 1'b0);

    // Random patterns with random short glitches or bounces in front.
    for (int s = 0; s < 30; s++) begin
      v = 16'd0;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) v[$urandom_range(0, 15)] = 1'b1;
      case ($urandom_range(0, 2))
        0: step(v, 0, 16'd0, 1'b0);
        1: step(v, $urandom_range(1, 70), 16'($urandom), 1'b0);
        default: step(v, 80, 16'd0, 1'b1);
      endcase
    end

    // Hold idx 15, reset mid-frame, expect a fresh press afterwards.
    step(16'h0000, 0, 16'd0, 1'b0);
    step(16'h8000, 0, 16'd0, 1'b0);
    repeat (13) @(negedge CLK_50M);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_row",   32'(ROW),       32'hE);
    chk("mid_rst_state", 32'(key_state), 32'd0);
    chk("mid_rst_press", 32'(key_press), 32'd0);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_code",  32'(key_code),  32'd0);
    repeat (3) @(negedge CLK_50M);
    accepted  = 16'd0;
    last_code = 4'd0;
    RST_N = 1'b1;
    step(16'h8000, 0, 16'd0, 1'b0);

    repeat (20) @(negedge CLK_50M);
    chk("final_queue", 32'(exp_vec_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
